pc_sequencer_irq: RTL and testbench

Parametrised next-PC sequencer with a vectored, prioritised, multi-channel interrupt controller. It replaces the ad-hoc PC mux and single-keyboard-interrupt logic in the CPU. Each cycle it selects the next PC from sequential, branch, jump and jump-register sources. It latches edge-triggered interrupt requests and, on service, saves a return PC and redirects fetch to a per-channel vector. Sits between the FSM/decoder control outputs and the instruction memory PC input.

---
 rtl/pc_sequencer_irq_if.sv | 38 +++
 rtl/pc_sequencer_irq.sv | 129 ++++++++++++
 tb/tb_pc_sequencer_irq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_irq_if.sv
// Control/result bundle between the decoder/FSM (master) and the PC sequencer (slave).
interface pc_sequencer_irq_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_IRQ = 4
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  logic               stall;
  logic               branch_taken;
  logic [15:0]        branch_imm;
  logic               jump_en;
  logic [WIDTH-1:0]   jump_target;
  logic               jr_en;
  logic [WIDTH-1:0]   jr_target;
  logic               eret;
  logic               irq_enable;
  logic [NUM_IRQ-1:0] irq_req;

  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   pc_plus4;
  logic [WIDTH-1:0]   epc;
  logic [NUM_IRQ-1:0] irq_pending;
  logic               irq_active;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_IRQ-1:0] irq_ack;

  modport master (
    output stall, branch_taken, branch_imm, jump_en, jump_target,
           jr_en, jr_target, eret, irq_enable, irq_req,
    input  pc, pc_plus4, epc, irq_pending, irq_active, irq_id, irq_ack
  );

  modport slave (
    input  stall, branch_taken, branch_imm, jump_en, jump_target,
           jr_en, jr_target, eret, irq_enable, irq_req,
    output pc, pc_plus4, epc, irq_pending, irq_active, irq_id, irq_ack
  );
endinterface

// File: rtl/pc_sequencer_irq.sv
// Next-PC sequencer with a vectored, lowest-index-first, non-nesting interrupt controller.
module pc_sequencer_irq #(
  parameter int               WIDTH         = 32,
  parameter int               NUM_IRQ       = 4,
  parameter logic [WIDTH-1:0] RESET_PC      = '0,
  parameter logic [WIDTH-1:0] VECTOR_BASE   = WIDTH'(32'h100),
  parameter int               VECTOR_STRIDE = 16
) (
  input  logic                clk,
  input  logic                reset,
  pc_sequencer_irq_if.slave   bus
);
  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {ST_RUN, ST_ISR} state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_epc;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_reqPrev;
  logic               r_active;
  logic [ID_W-1:0]    r_id;
  logic [NUM_IRQ-1:0] r_ack;

  state_t             w_stateNext;
  logic [WIDTH-1:0]   w_pcNext;
  logic [WIDTH-1:0]   w_epcNext;
  logic [NUM_IRQ-1:0] w_pendingNext;
  logic               w_activeNext;
  logic [ID_W-1:0]    w_idNext;
  logic [NUM_IRQ-1:0] w_ackNext;

  logic [WIDTH-1:0]   w_pcPlus4;
  logic [WIDTH-1:0]   w_immExt;
  logic [WIDTH-1:0]   w_seqNext;
  logic [NUM_IRQ-1:0] w_edges;
  logic [ID_W-1:0]    w_winId;
  logic [WIDTH-1:0]   w_vector;

  assign w_pcPlus4 = r_pc + WIDTH'(4);
  assign w_immExt  = WIDTH'($signed(bus.branch_imm));
  assign w_edges   = bus.irq_req & ~r_reqPrev;
  assign w_vector  = VECTOR_BASE + (WIDTH'(w_winId) * WIDTH'(VECTOR_STRIDE));

  always_comb begin
    w_seqNext = w_pcPlus4;
    if (bus.jr_en)             w_seqNext = bus.jr_target;
    else if (bus.jump_en)      w_seqNext = bus.jump_target;
    else if (bus.branch_taken) w_seqNext = w_pcPlus4 + (w_immExt << 2);
  end

  // Scan downwards so the lowest pending index is the last one written.
  always_comb begin
    w_winId = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i]) w_winId = ID_W'(i);
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_pcNext     = r_pc;
    w_epcNext    = r_epc;
    w_activeNext = r_active;
    w_idNext     = r_id;
    w_ackNext    = '0;
    case (r_state)
      ST_RUN: begin
        if (!bus.stall) begin
          if (bus.irq_enable && (|r_pending)) begin
            w_epcNext    = w_seqNext;
            w_pcNext     = w_vector;
            w_ackNext    = NUM_IRQ'(1) << w_winId;
            w_idNext     = w_winId;
            w_activeNext = 1'b1;
            w_stateNext  = ST_ISR;
          end else begin
            w_pcNext = w_seqNext;
          end
        end
      end
      ST_ISR: begin
        if (!bus.stall) begin
          if (bus.eret) begin
            w_pcNext     = r_epc;
            w_activeNext = 1'b0;
            w_stateNext  = ST_RUN;
          end else begin
            w_pcNext = w_seqNext;
          end
        end
      end
      default: w_stateNext = ST_RUN;
    endcase
    // A fresh edge in the ack cycle re-arms the channel.
    w_pendingNext = (r_pending & ~w_ackNext) | w_edges;
  end

  always_ff @(posedge clk) begin
    // History follows the input even in reset so a level held across release is not an edge.
    r_reqPrev <= bus.irq_req;
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_epc     <= '0;
      r_pending <= '0;
      r_active  <= 1'b0;
      r_id      <= '0;
      r_ack     <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_epc     <= w_epcNext;
      r_pending <= w_pendingNext;
      r_active  <= w_activeNext;
      r_id      <= w_idNext;
      r_ack     <= w_ackNext;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.pc_plus4    = w_pcPlus4;
  assign bus.epc         = r_epc;
  assign bus.irq_pending = r_pending;
  assign bus.irq_active  = r_active;
  assign bus.irq_id      = r_id;
  assign bus.irq_ack     = r_ack;
endmodule

// File: tb/tb_pc_sequencer_irq.sv
// Directed table-driven bench for pc_sequencer_irq (WIDTH=32, NUM_IRQ=4, vectors at 0x100 + 16*id).
module tb_pc_sequencer_irq;
  localparam int WIDTH   = 32;
  localparam int NUM_IRQ = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pc_sequencer_irq_if #(.WIDTH(WIDTH), .NUM_IRQ(NUM_IRQ)) bus();

  pc_sequencer_irq #(
    .WIDTH(WIDTH), .NUM_IRQ(NUM_IRQ), .RESET_PC(32'h0),
    .VECTOR_BASE(32'h100), .VECTOR_STRIDE(16)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // ctl bits: {irq_enable, stall, branch_taken, jump_en, jr_en, eret}
  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] jt;
    logic [31:0] jrt;
    logic [15:0] imm;
    logic [3:0]  req;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [3:0]  pend;
    logic        act;
    logic [3:0]  ack;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mkVec(input logic [5:0] ctl, input logic [31:0] jt, input logic [31:0] jrt,
                                 input logic [15:0] imm, input logic [3:0] req, input logic [31:0] pc,
                                 input logic [31:0] epc, input logic [3:0] pend, input logic act,
                                 input logic [3:0] ack, input logic [1:0] id);
    vec_t v;
    v.ctl = ctl; v.jt = jt; v.jrt = jrt; v.imm = imm; v.req = req;
    v.pc = pc; v.epc = epc; v.pend = pend; v.act = act; v.ack = ack; v.id = id;
    return v;
  endfunction

  task automatic addVec(input logic [5:0] ctl, input logic [31:0] jt, input logic [31:0] jrt,
                        input logic [15:0] imm, input logic [3:0] req, input logic [31:0] pc,
                        input logic [31:0] epc, input logic [3:0] pend, input logic act,
                        input logic [3:0] ack, input logic [1:0] id);
    vecs.push_back(mkVec(ctl, jt, jrt, imm, req, pc, epc, pend, act, ack, id));
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.irq_enable   = v.ctl[5];
    bus.stall        = v.ctl[4];
    bus.branch_taken = v.ctl[3];
    bus.jump_en      = v.ctl[2];
    bus.jr_en        = v.ctl[1];
    bus.eret         = v.ctl[0];
    bus.jump_target  = v.jt;
    bus.jr_target    = v.jrt;
    bus.branch_imm   = v.imm;
    bus.irq_req      = v.req;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkRow(input string tag, input vec_t v);
    checkOutput({tag, " pc"},       bus.pc, v.pc);
    checkOutput({tag, " pc_plus4"}, bus.pc_plus4, v.pc + 32'd4);
    checkOutput({tag, " epc"},      bus.epc, v.epc);
    checkOutput({tag, " pending"},  32'(bus.irq_pending), 32'(v.pend));
    checkOutput({tag, " active"},   32'(bus.irq_active), 32'(v.act));
    checkOutput({tag, " ack"},      32'(bus.irq_ack), 32'(v.ack));
    checkOutput({tag, " id"},       32'(bus.irq_id), 32'(v.id));
  endtask

  initial begin
    // Sequential run, branch/jump/jr priority, single and multi-channel service.
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h004, 32'h000, 4'b0000, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h008, 32'h000, 4'b0000, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h00C, 32'h000, 4'b0000, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0100, 32'h010, 32'h000, 4'b0100, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h120, 32'h014, 4'b0000, 1, 4'b0100, 2);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h124, 32'h014, 4'b0000, 1, 4'b0000, 2);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h014, 32'h014, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b100100, 32'h20, 0, 0, 4'b0000, 32'h020, 32'h014, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b101000, 0, 0, 16'hFFFE, 4'b0000, 32'h01C, 32'h014, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b100110, 32'h80, 32'h40, 0, 4'b0000, 32'h040, 32'h014, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b101000, 0, 0, 16'h0003, 4'b0000, 32'h050, 32'h014, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b100000, 0, 0, 0, 4'b1010, 32'h054, 32'h014, 4'b1010, 0, 4'b0000, 2);
    addVec(6'b100000, 0, 0, 0, 4'b1010, 32'h110, 32'h058, 4'b1000, 1, 4'b0010, 1);
    addVec(6'b100000, 0, 0, 0, 4'b1011, 32'h114, 32'h058, 4'b1001, 1, 4'b0000, 1);
    addVec(6'b100001, 0, 0, 0, 4'b1011, 32'h058, 32'h058, 4'b1001, 0, 4'b0000, 1);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h100, 32'h05C, 4'b1000, 1, 4'b0001, 0);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h05C, 32'h05C, 4'b1000, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h130, 32'h060, 4'b0000, 1, 4'b1000, 3);
    addVec(6'b100011, 0, 32'h400, 0, 4'b0000, 32'h060, 32'h060, 4'b0000, 0, 4'b0000, 3);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h064, 32'h060, 4'b0000, 0, 4'b0000, 3);
    // Take in the same cycle as a jump, then stalls in RUN and ISR.
    addVec(6'b100000, 0, 0, 0, 4'b0100, 32'h068, 32'h060, 4'b0100, 0, 4'b0000, 3);
    addVec(6'b100100, 32'h200, 0, 0, 4'b0000, 32'h120, 32'h200, 4'b0000, 1, 4'b0100, 2);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h200, 32'h200, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b100000, 0, 0, 0, 4'b0001, 32'h204, 32'h200, 4'b0001, 0, 4'b0000, 2);
    addVec(6'b110000, 0, 0, 0, 4'b0001, 32'h204, 32'h200, 4'b0001, 0, 4'b0000, 2);
    addVec(6'b110000, 0, 0, 0, 4'b0000, 32'h204, 32'h200, 4'b0001, 0, 4'b0000, 2);
    addVec(6'b110000, 0, 0, 0, 4'b0000, 32'h204, 32'h200, 4'b0001, 0, 4'b0000, 2);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h100, 32'h208, 4'b0000, 1, 4'b0001, 0);
    addVec(6'b110001, 0, 0, 0, 4'b0000, 32'h100, 32'h208, 4'b0000, 1, 4'b0000, 0);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h208, 32'h208, 4'b0000, 0, 4'b0000, 0);
    // Disabled interrupts latch only; re-edge in the ack cycle keeps the bit pending.
    addVec(6'b000000, 0, 0, 0, 4'b0100, 32'h20C, 32'h208, 4'b0100, 0, 4'b0000, 0);
    addVec(6'b000000, 0, 0, 0, 4'b0000, 32'h210, 32'h208, 4'b0100, 0, 4'b0000, 0);
    addVec(6'b100000, 0, 0, 0, 4'b0000, 32'h120, 32'h214, 4'b0000, 1, 4'b0100, 2);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h214, 32'h214, 4'b0000, 0, 4'b0000, 2);
    addVec(6'b000000, 0, 0, 0, 4'b0010, 32'h218, 32'h214, 4'b0010, 0, 4'b0000, 2);
    addVec(6'b000000, 0, 0, 0, 4'b0000, 32'h21C, 32'h214, 4'b0010, 0, 4'b0000, 2);
    addVec(6'b100000, 0, 0, 0, 4'b0010, 32'h110, 32'h220, 4'b0010, 1, 4'b0010, 1);
    addVec(6'b100001, 0, 0, 0, 4'b0010, 32'h220, 32'h220, 4'b0010, 0, 4'b0000, 1);
    addVec(6'b100000, 0, 0, 0, 4'b0010, 32'h110, 32'h224, 4'b0000, 1, 4'b0010, 1);
    addVec(6'b100001, 0, 0, 0, 4'b0000, 32'h224, 32'h224, 4'b0000, 0, 4'b0000, 1);

    reset = 1'b1;
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    checkRow("reset", mkVec(6'b0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 4'b0, 0, 4'b0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkRow($sformatf("row%0d", i), vecs[i]);
    end

    // Reset mid-ISR with a pending channel and an irq_req level held across release.
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    checkOutput("midisr pend0", 32'(bus.irq_pending), 32'h1);
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    checkOutput("midisr take pc", bus.pc, 32'h100);
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0));
    checkOutput("midisr pend1", 32'(bus.irq_pending), 32'h2);
    checkOutput("midisr active", 32'(bus.irq_active), 32'h1);
    reset = 1'b1;
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;
    checkRow("midreset", mkVec(6'b0, 0, 0, 0, 4'b0, 32'h0, 32'h0, 4'b0, 0, 4'b0, 0));
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0));
    checkRow("held1", mkVec(6'b0, 0, 0, 0, 4'b0, 32'h4, 32'h0, 4'b0, 0, 4'b0, 0));
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0011, 0, 0, 0, 0, 0, 0));
    checkRow("held2", mkVec(6'b0, 0, 0, 0, 4'b0, 32'h8, 32'h0, 4'b0, 0, 4'b0, 0));
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0));
    checkOutput("fall pc", bus.pc, 32'hC);
    applyStimulus(mkVec(6'b100000, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
    checkOutput("fresh edge pend", 32'(bus.irq_pending), 32'h2);
    checkOutput("fresh edge pc", bus.pc, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
